// File: rtl/seg7_scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux_pkg
// Shared constants and the hex glyph helper for the 7-segment scan driver.
//   KILO / MEGA : frequency scaling helpers
//   SEG_BLANK   : all segments dark (active-low)
//   hex_glyph() : 4-bit nibble -> {g,f,e,d,c,b,a} active-low segment pattern
// -----------------------------------------------------------------------------
package seg7_scan_mux_pkg;

    localparam int KILO = 32'd1_000;
    localparam int MEGA = 32'd1_000_000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Full hex glyph set; letters b and d are lower-case so they differ from 8 and 0.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Combinational hex nibble to active-low 7-segment pattern.
//   i_nibble : 4-bit hex value
//   o_seg    : {CG,CF,CE,CD,CC,CB,CA}, active-low
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup.
    always_comb begin
        o_seg = hex_glyph(i_nibble);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed driver for a common-anode 7-segment bank. One digit is
// selected per slot; within a slot an 8-step phase counter provides PWM
// brightness. Adds per-digit enable, decimal point, blink and leading-zero
// blanking. All pin outputs come from one register stage.
//   clk, reset  : single clock, synchronous active-high reset
//   digits      : hex nibble per digit, [3:0] = digit 0 (rightmost)
//   dp          : decimal point request per digit, 1 = lit
//   digit_en    : 1 = digit may light
//   blink_mask  : 1 = digit dark during blink off-phase
//   lzb         : leading-zero blanking enable
//   brightness  : 0 = 1/8 duty .. 7 = full duty
//   seg, DP, AN : active-low cathodes / decimal point / anodes
// -----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_HZ  = 1000,
    parameter int BLINK_HZ    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lzb,
    input  logic [2:0]              brightness,
    output logic [6:0]              seg,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int SUB_RAW    = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS * 8);
    localparam int SUB        = (SUB_RAW < 1) ? 1 : SUB_RAW;
    localparam int BLINK_RAW  = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;

    localparam logic [31:0] SUB_LAST   = 32'(SUB - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [31:0]           r_sub_cnt;
    logic [2:0]            r_phase;
    logic [2:0]            r_idx;
    logic [31:0]           r_blink_cnt;
    logic                  r_blink_on;

    logic [NUM_DIGITS-1:0] w_lzblank;
    logic [3:0]            w_nibble;
    logic                  w_sel_en;
    logic                  w_sel_bm;
    logic                  w_sel_lz;
    logic                  w_sel_dp;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic                  w_lit;
    logic [6:0]            w_glyph;

    // Scan counters: sub-step -> phase -> digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sub_cnt <= 32'd0;
            r_phase   <= 3'd0;
            r_idx     <= 3'd0;
        end else if (r_sub_cnt == SUB_LAST) begin
            r_sub_cnt <= 32'd0;
            r_phase   <= r_phase + 3'd1;
            if (r_phase == 3'd7) begin
                r_idx <= (r_idx == IDX_LAST) ? 3'd0 : (r_idx + 3'd1);
            end else begin
                r_idx <= r_idx;
            end
        end else begin
            r_sub_cnt <= r_sub_cnt + 32'd1;
            r_phase   <= r_phase;
            r_idx     <= r_idx;
        end
    end

    // Free-running blink timebase, independent of the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= 32'd0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= 32'd0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
            r_blink_on  <= r_blink_on;
        end
    end

    // Leading-zero blank: walk from the leftmost digit while all nibbles seen are zero.
    always_comb begin
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lzblank  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_all_zero = v_all_zero & (digits[4*k +: 4] == 4'd0);
            if (k > 0) begin
                w_lzblank[k] = lzb & v_all_zero;
            end else begin
                w_lzblank[k] = 1'b0;
            end
        end
    end

    // Select the per-digit controls for the digit currently being scanned.
    always_comb begin
        w_nibble = 4'd0;
        w_sel_en = 1'b0;
        w_sel_bm = 1'b0;
        w_sel_lz = 1'b0;
        w_sel_dp = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_nibble    = digits[4*k +: 4];
                w_sel_en    = digit_en[k];
                w_sel_bm    = blink_mask[k];
                w_sel_lz    = w_lzblank[k];
                w_sel_dp    = dp[k];
                w_an_sel[k] = 1'b0;
            end else begin
                w_an_sel[k] = 1'b1;
            end
        end
    end

    // Brightness compares against the live phase so a change takes effect next cycle.
    always_comb begin
        w_lit = w_sel_en & ~(w_sel_bm & ~r_blink_on) & ~w_sel_lz & (r_phase <= brightness);
    end

    seg7_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Single output register stage; anode and cathodes always change together so a dark slot cannot ghost.
    always_ff @(posedge clk) begin
        if (reset) begin
            AN  <= '1;
            seg <= SEG_BLANK;
            DP  <= 1'b1;
        end else if (w_lit) begin
            AN  <= w_an_sel;
            seg <= w_glyph;
            DP  <= ~w_sel_dp;
        end else begin
            AN  <= '1;
            seg <= SEG_BLANK;
            DP  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int CLK_FREQ_HZ = 6400;
    localparam int REFRESH_HZ  = 100;
    localparam int NUM_DIGITS  = 8;
    localparam int BLINK_HZ    = 50;
    localparam int SUB         = 1;
    localparam int BLINK_HALF  = 64;

    logic        clk;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic [7:0]  blink_mask;
    logic        lzb;
    logic [2:0]  brightness;
    logic [6:0]  seg;
    logic        DP;
    logic [7:0]  AN;

    int checks_cnt;
    int fail_cnt;

    logic [6:0] glyph [16];

    int          t_model;
    logic [15:0] exp_out;
    logic        exp_valid;
    logic        done;

    seg7_scan_mux #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_HZ  (REFRESH_HZ),
        .BLINK_HZ    (BLINK_HZ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .brightness (brightness),
        .seg        (seg),
        .DP         (DP),
        .AN         (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s observed=%h expected=%h time=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: output after the t-th clock since reset release, written from the timing rules.
    function automatic logic [15:0] ref_out(input int t, input logic [31:0] dg, input logic [7:0] dpv,
                                            input logic [7:0] en, input logic [7:0] bm, input logic lz,
                                            input logic [2:0] br);
        int   idx;
        int   ph;
        bit   bon;
        bit   lzblank;
        bit   lit;
        logic [3:0] nib;
        idx     = (t / (8 * SUB)) % NUM_DIGITS;
        ph      = (t / SUB) % 8;
        bon     = ((t / BLINK_HALF) % 2) == 0;
        lzblank = lz && (idx > 0) && ((dg >> (4 * idx)) == 32'd0);
        lit     = en[idx] && !(bm[idx] && !bon) && !lzblank && (ph <= int'(br));
        nib     = dg[4*idx +: 4];
        if (lit) return {~(8'd1 << idx), glyph[nib], ~dpv[idx]};
        else     return {8'hFF, 7'h7F, 1'b1};
    endfunction

    // Model timeline, advanced on the same edge the DUT registers.
    always @(posedge clk) begin
        if (reset) begin
            t_model   <= 0;
            exp_out   <= 16'hFFFF;
            exp_valid <= 1'b1;
        end else begin
            t_model <= t_model + 1;
            exp_out <= ref_out(t_model, digits, dp, digit_en, blink_mask, lzb, brightness);
        end
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        if (exp_valid && !done) begin
            chk("out", {16'd0, AN, seg, DP}, {16'd0, exp_out});
            chk("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
        end
    end

    task automatic set_inputs(input logic [31:0] dg, input logic [7:0] dpv, input logic [7:0] en,
                              input logic [7:0] bm, input logic lz, input logic [2:0] br);
        digits = dg; dp = dpv; digit_en = en; blink_mask = bm; lzb = lz; brightness = br;
    endtask

    task automatic duty_check(input string tag, input logic [2:0] br, input int exp_lit);
        int lit_cnt;
        set_inputs(32'h12345678, 8'h00, 8'hFF, 8'h00, 1'b0, br);
        @(negedge clk);
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (AN != 8'hFF) lit_cnt++;
        end
        chk(tag, 32'(lit_cnt), 32'(exp_lit));
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        checks_cnt = 0;
        fail_cnt   = 0;
        exp_valid  = 1'b0;
        done       = 1'b0;
        reset      = 1'b1;
        set_inputs(32'h12345678, 8'h00, 8'hFF, 8'h00, 1'b0, 3'd7);

        repeat (3) @(negedge clk);
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        @(negedge clk);
        chk("first_an", 32'(AN), 32'hFE);
        chk("first_seg", 32'(seg), 32'h00);
        repeat (8) @(negedge clk);
        chk("second_an", 32'(AN), 32'hFD);
        chk("second_seg", 32'(seg), 32'h78);
        repeat (48) @(negedge clk);
        chk("last_an", 32'(AN), 32'h7F);
        repeat (8) @(negedge clk);
        chk("wrap_an", 32'(AN), 32'hFE);

        duty_check("duty_b0", 3'd0, 8);
        duty_check("duty_b3", 3'd3, 32);
        duty_check("duty_b7", 3'd7, 64);

        // Leading-zero, blink and decimal-point scenarios, checked by the model each cycle.
        set_inputs(32'h00000305, 8'h00, 8'hFF, 8'h00, 1'b1, 3'd7);
        repeat (70) @(negedge clk);
        set_inputs(32'h00000000, 8'h00, 8'hFF, 8'h00, 1'b1, 3'd7);
        repeat (70) @(negedge clk);
        set_inputs(32'h89ABCDEF, 8'h00, 8'hFF, 8'h03, 1'b0, 3'd7);
        repeat (200) @(negedge clk);
        set_inputs(32'h01234567, 8'h04, 8'hFB, 8'h00, 1'b0, 3'd7);
        repeat (70) @(negedge clk);
        set_inputs(32'h01234567, 8'h04, 8'hFF, 8'h00, 1'b0, 3'd7);
        repeat (70) @(negedge clk);

        // Reset in the middle of digit 5's slot.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (44) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(AN), 32'hFF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_an", 32'(AN), 32'hFE);
        repeat (8) @(negedge clk);
        chk("restart_slot", 32'(AN), 32'hFD);

        // Randomized segments with varied hold times.
        for (int s = 0; s < 40; s++) begin
            set_inputs($urandom >> (4 * $urandom_range(0, 8)), 8'($urandom), 8'($urandom | $urandom),
                       8'($urandom), 1'($urandom), 3'($urandom));
            repeat ($urandom_range(1, 120)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        // Inputs changing every cycle.
        for (int s = 0; s < 300; s++) begin
            set_inputs($urandom >> (4 * $urandom_range(0, 8)), 8'($urandom), 8'($urandom),
                       8'($urandom), 1'($urandom), 3'($urandom));
            @(negedge clk);
        end

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
